// File: rtl/cpu_pkg.sv
// Shared decoder definitions: opcodes, writeback-select codes, FSM states and
// the opcode-to-class decode used by decoder_pipe.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_CALL  = 5'b00001;
    localparam logic [4:0] OP_CMP_R = 5'b00010;
    localparam logic [4:0] OP_CMP_I = 5'b00011;
    localparam logic [4:0] OP_JMP_R = 5'b00100;
    localparam logic [4:0] OP_JMP_I = 5'b00101;
    localparam logic [4:0] OP_RTN   = 5'b11100;
    localparam logic [4:0] OP_STP   = 5'b11111;

    localparam logic [2:0] SEL_RS  = 3'b000;
    localparam logic [2:0] SEL_N   = 3'b010;
    localparam logic [2:0] SEL_ALU = 3'b100;
    localparam logic [2:0] SEL_MAS = 3'b101;
    localparam logic [2:0] SEL_RPC = 3'b001;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_CALL,
        CLS_CMP,
        CLS_JMP_R,
        CLS_JMP_I,
        CLS_ALU,
        CLS_MAS,
        CLS_MOV,
        CLS_RTN,
        CLS_HALT
    } op_class_t;

    // STP and every unlisted opcode fall through to CLS_HALT.
    function automatic op_class_t decode_op(input logic [4:0] op);
        op_class_t cls;
        casez (op)
            OP_NOP:   cls = CLS_NOP;
            OP_CALL:  cls = CLS_CALL;
            5'b0001?: cls = CLS_CMP;
            OP_JMP_R: cls = CLS_JMP_R;
            OP_JMP_I: cls = CLS_JMP_I;
            5'b010??: cls = CLS_ALU;
            5'b0110?: cls = CLS_MAS;
            5'b0111?: cls = CLS_MOV;
            OP_RTN:   cls = CLS_RTN;
            default:  cls = CLS_HALT;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/decoder_pipe_if.sv
// Instruction delivery bus: instruction, immediate, ALU flag and register-file
// read data presented together under a valid/ready handshake.
interface decoder_pipe_if #(
    parameter int DW = 16
) ();

    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;
    logic [DW-1:0] N;
    logic          jump;
    logic [DW-1:0] rddata;
    logic [DW-1:0] rsdata;

    modport master (
        output instr_valid,
        output instr,
        output N,
        output jump,
        output rddata,
        output rsdata,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        input  N,
        input  jump,
        input  rddata,
        input  rsdata,
        output instr_ready
    );

endinterface

// File: rtl/ras_stack.sv
// Return-address stack: LIFO of RAS_DEPTH entries with a 0..RAS_DEPTH fill count.
// Pushes when full and pops when empty are ignored; the caller flags them.
module ras_stack #(
    parameter int DW        = 16,
    parameter int RAS_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [RAS_DEPTH];
    logic [CW-1:0] count_reg;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;
    logic          do_push;
    logic          do_pop;

    assign wr_idx  = count_reg[AW-1:0];
    assign top_idx = wr_idx - AW'(1);
    assign full    = (count_reg == CW'(RAS_DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // The top entry must be visible in the same cycle a RTN is decoded,
    // so the read is asynchronous from this small register array.
    assign dout = mem[top_idx];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (do_push) begin
            count_reg <= count_reg + CW'(1);
        end else if (do_pop) begin
            count_reg <= count_reg - CW'(1);
        end
    end

endmodule

// File: rtl/decoder_pipe.sv
// Instruction decoder and PC sequencer: decodes one accepted instruction per
// cycle into a registered next PC, writeback select and write strobes.
module decoder_pipe
    import cpu_pkg::*;
#(
    parameter int DW        = 16,
    parameter int RAS_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    decoder_pipe_if.slave bus,
    output logic [DW-1:0] pc,
    output logic [DW-1:0] instr_addr1,
    output logic [DW-1:0] instr_addr2,
    output logic [2:0]    giantmux_sel,
    output logic          rd_wen,
    output logic          rs_wen,
    output logic          halted,
    output logic          ras_err
);

    state_t        state_reg, state_next;
    logic [DW-1:0] pc_reg, pc_next;
    logic [2:0]    sel_reg, sel_next;
    logic          rd_wen_reg, rd_wen_next;
    logic          rs_wen_reg, rs_wen_next;
    logic          ras_err_reg, ras_err_next;

    logic [4:0]    opcode;
    logic [1:0]    cond;
    op_class_t     op_class;
    logic          accept;
    logic [DW-1:0] base;
    logic [DW-1:0] pc_seq;
    logic [DW-1:0] pc_skip;

    logic          ras_push;
    logic          ras_pop;
    logic [DW-1:0] ras_dout;
    logic          ras_full;
    logic          ras_empty;

    // rsdata feeds the external writeback mux only; the middle instruction
    // bits are operand fields decoded elsewhere.
    logic unused_bits;
    assign unused_bits = ^{bus.rsdata, bus.instr[DW-6:2]};

    assign opcode   = bus.instr[DW-1 -: 5];
    assign cond     = bus.instr[1:0];
    assign op_class = decode_op(opcode);
    assign accept   = bus.instr_valid && (state_reg != ST_HALT);
    assign base     = opcode[0] ? DW'(2) : DW'(1);
    assign pc_seq   = pc_reg + base;
    assign pc_skip  = pc_seq + DW'(cond) + DW'(1);

    ras_stack #(
        .DW        (DW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_seq),
        .dout  (ras_dout),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        sel_next     = SEL_RS;
        rd_wen_next  = 1'b0;
        rs_wen_next  = 1'b0;
        ras_err_next = ras_err_reg;
        ras_push     = 1'b0;
        ras_pop      = 1'b0;

        if (state_reg == ST_HALT) begin
            state_next = ST_HALT;
        end else if (!accept) begin
            state_next = ST_WAIT;
        end else begin
            state_next = ST_RUN;
            case (op_class)
                CLS_NOP: begin
                    pc_next = pc_seq;
                end
                CLS_CALL: begin
                    if (ras_full) begin
                        ras_err_next = 1'b1;
                        state_next   = ST_HALT;
                    end else begin
                        ras_push    = 1'b1;
                        pc_next     = bus.N;
                        sel_next    = SEL_RPC;
                        rd_wen_next = 1'b1;
                    end
                end
                CLS_RTN: begin
                    if (ras_empty) begin
                        ras_err_next = 1'b1;
                        state_next   = ST_HALT;
                    end else begin
                        ras_pop = 1'b1;
                        pc_next = ras_dout;
                    end
                end
                CLS_JMP_R: begin
                    pc_next = bus.rddata;
                end
                CLS_JMP_I: begin
                    pc_next = bus.N;
                end
                CLS_CMP: begin
                    pc_next = bus.jump ? pc_skip : pc_seq;
                end
                CLS_ALU: begin
                    pc_next     = pc_seq;
                    sel_next    = SEL_ALU;
                    rd_wen_next = 1'b1;
                end
                CLS_MAS: begin
                    pc_next     = pc_seq;
                    sel_next    = SEL_MAS;
                    rd_wen_next = 1'b1;
                end
                CLS_MOV: begin
                    pc_next     = pc_seq;
                    sel_next    = opcode[0] ? SEL_N : SEL_RS;
                    rd_wen_next = 1'b1;
                end
                default: begin
                    state_next = ST_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_RUN;
            pc_reg      <= '0;
            sel_reg     <= SEL_RS;
            rd_wen_reg  <= 1'b0;
            rs_wen_reg  <= 1'b0;
            ras_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            sel_reg     <= sel_next;
            rd_wen_reg  <= rd_wen_next;
            rs_wen_reg  <= rs_wen_next;
            ras_err_reg <= ras_err_next;
        end
    end

    assign bus.instr_ready = (state_reg != ST_HALT);
    assign pc              = pc_reg;
    assign instr_addr1     = pc_reg;
    assign instr_addr2     = pc_reg + DW'(1);
    assign giantmux_sel    = sel_reg;
    assign rd_wen          = rd_wen_reg;
    assign rs_wen          = rs_wen_reg;
    assign halted          = (state_reg == ST_HALT);
    assign ras_err         = ras_err_reg;

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed bench for decoder_pipe: a vector table on a DW=16 instance plus
// hand sequences for the stack limits, reset, and 8-bit PC wrap.
module tb_decoder_pipe;

    logic clk;
    logic rst_n16;
    logic rst_n8;

    logic [15:0] pc16, addr1_16, addr2_16;
    logic [2:0]  sel16;
    logic        rd_wen16, rs_wen16, halted16, ras_err16;
    logic [7:0]  pc8, addr1_8, addr2_8;
    logic [2:0]  sel8;
    logic        rd_wen8, rs_wen8, halted8, ras_err8;

    int checks = 0;
    int errors = 0;

    decoder_pipe_if #(.DW(16)) bus16 ();
    decoder_pipe_if #(.DW(8))  bus8 ();

    decoder_pipe #(.DW(16), .RAS_DEPTH(8)) u_dut16 (
        .clk          (clk),
        .rst_n        (rst_n16),
        .bus          (bus16),
        .pc           (pc16),
        .instr_addr1  (addr1_16),
        .instr_addr2  (addr2_16),
        .giantmux_sel (sel16),
        .rd_wen       (rd_wen16),
        .rs_wen       (rs_wen16),
        .halted       (halted16),
        .ras_err      (ras_err16)
    );

    decoder_pipe #(.DW(8), .RAS_DEPTH(8)) u_dut8 (
        .clk          (clk),
        .rst_n        (rst_n8),
        .bus          (bus8),
        .pc           (pc8),
        .instr_addr1  (addr1_8),
        .instr_addr2  (addr2_8),
        .giantmux_sel (sel8),
        .rd_wen       (rd_wen8),
        .rs_wen       (rs_wen8),
        .halted       (halted8),
        .ras_err      (ras_err8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        valid;
        logic [4:0]  op;
        logic [1:0]  cond;
        logic [15:0] n;
        logic        jump;
        logic [15:0] rd;
        logic [15:0] exp_pc;
        logic [2:0]  exp_sel;
        logic        exp_wen;
        logic        exp_halt;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue16(input logic v, input logic [4:0] op, input logic [1:0] cnd,
                           input logic [15:0] n, input logic j, input logic [15:0] rd);
        @(negedge clk);
        bus16.instr_valid = v;
        bus16.instr       = {op, 9'd0, cnd};
        bus16.N           = n;
        bus16.jump        = j;
        bus16.rddata      = rd;
        bus16.rsdata      = 16'hA5A5;
        @(posedge clk);
        #1;
        $display("txn16 valid=%0b op=%b cond=%0d n=%h jump=%0b rd=%h -> pc=%h sel=%b rd_wen=%0b halted=%0b ras_err=%0b",
                 v, op, cnd, n, j, rd, pc16, sel16, rd_wen16, halted16, ras_err16);
    endtask

    task automatic issue8(input logic v, input logic [4:0] op, input logic [7:0] n);
        @(negedge clk);
        bus8.instr_valid = v;
        bus8.instr       = {op, 3'd0};
        bus8.N           = n;
        bus8.jump        = 1'b0;
        bus8.rddata      = 8'h00;
        bus8.rsdata      = 8'h00;
        @(posedge clk);
        #1;
        $display("txn8 valid=%0b op=%b n=%h -> pc=%h halted=%0b", v, op, n, pc8, halted8);
    endtask

    task automatic reset16();
        @(negedge clk);
        rst_n16           = 1'b0;
        bus16.instr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n16 = 1'b1;
        $display("txn16 reset -> pc=%h halted=%0b ras_err=%0b", pc16, halted16, ras_err16);
    endtask

    task automatic chk16(input string nm, input logic [15:0] epc, input logic ewen,
                         input logic ehalt, input logic eerr);
        chk({nm, "_pc"}, 32'(pc16), 32'(epc));
        chk({nm, "_addr1"}, 32'(addr1_16), 32'(epc));
        chk({nm, "_addr2"}, 32'(addr2_16), 32'(16'(epc + 16'd1)));
        chk({nm, "_rd_wen"}, 32'(rd_wen16), 32'(ewen));
        chk({nm, "_rs_wen"}, 32'(rs_wen16), 32'd0);
        chk({nm, "_halted"}, 32'(halted16), 32'(ehalt));
        chk({nm, "_ready"}, 32'(bus16.instr_ready), 32'(!ehalt));
        chk({nm, "_ras_err"}, 32'(ras_err16), 32'(eerr));
    endtask

    initial begin
        rst_n16 = 1'b0;
        rst_n8  = 1'b0;
        bus16.instr_valid = 1'b0; bus16.instr = '0; bus16.N = '0;
        bus16.jump = 1'b0; bus16.rddata = '0; bus16.rsdata = '0;
        bus8.instr_valid = 1'b0; bus8.instr = '0; bus8.N = '0;
        bus8.jump = 1'b0; bus8.rddata = '0; bus8.rsdata = '0;

        //          valid  op        cond  n         jump  rd        exp_pc    sel     wen   halt
        vecs[0]  = '{1'b1, 5'b00000, 2'd0, 16'h0000, 1'b0, 16'h0000, 16'h0001, 3'b000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'b00000, 2'd0, 16'h0000, 1'b0, 16'h0000, 16'h0002, 3'b000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'b00000, 2'd0, 16'h0000, 1'b0, 16'h0000, 16'h0003, 3'b000, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'b00101, 2'd0, 16'h0040, 1'b0, 16'h0000, 16'h0040, 3'b000, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'b00001, 2'd0, 16'h0100, 1'b0, 16'h0000, 16'h0100, 3'b001, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 5'b11100, 2'd0, 16'h0000, 1'b0, 16'h0000, 16'h0042, 3'b000, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 5'b00100, 2'd0, 16'h0000, 1'b0, 16'h0005, 16'h0005, 3'b000, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 5'b00010, 2'd1, 16'h0000, 1'b1, 16'h0000, 16'h0008, 3'b000, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 5'b00100, 2'd0, 16'h0000, 1'b0, 16'h0005, 16'h0005, 3'b000, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 5'b00010, 2'd2, 16'h0000, 1'b0, 16'h0000, 16'h0006, 3'b000, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'b00010, 2'd2, 16'h0000, 1'b1, 16'h0000, 16'h000A, 3'b000, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 5'b00011, 2'd3, 16'h0000, 1'b1, 16'h0000, 16'h0010, 3'b000, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 5'b01000, 2'd0, 16'h0000, 1'b0, 16'h0000, 16'h0011, 3'b100, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 5'b01011, 2'd0, 16'h0000, 1'b0, 16'h0000, 16'h0013, 3'b100, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 5'b01101, 2'd0, 16'h0000, 1'b0, 16'h0000, 16'h0015, 3'b101, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 5'b01110, 2'd0, 16'h0000, 1'b0, 16'h0000, 16'h0016, 3'b000, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 5'b01111, 2'd0, 16'h0000, 1'b0, 16'h0000, 16'h0018, 3'b010, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 5'b01000, 2'd0, 16'h0000, 1'b0, 16'h0000, 16'h0018, 3'b000, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 5'b00101, 2'd0, 16'h0300, 1'b0, 16'h0000, 16'h0018, 3'b000, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 5'b00001, 2'd0, 16'h0300, 1'b0, 16'h0000, 16'h0018, 3'b000, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 5'b11111, 2'd0, 16'h0000, 1'b0, 16'h0000, 16'h0018, 3'b000, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 5'b00000, 2'd3, 16'h0000, 1'b1, 16'h0000, 16'h0019, 3'b000, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 5'b00011, 2'd1, 16'h0000, 1'b0, 16'h0000, 16'h001B, 3'b000, 1'b0, 1'b0};
        vecs[23] = '{1'b1, 5'b00101, 2'd0, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 3'b000, 1'b0, 1'b0};
        vecs[24] = '{1'b1, 5'b00000, 2'd0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b0};
        vecs[25] = '{1'b1, 5'b10000, 2'd0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1};
        vecs[26] = '{1'b1, 5'b00101, 2'd0, 16'h0055, 1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1};
        vecs[27] = '{1'b1, 5'b00001, 2'd0, 16'h0100, 1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst_n16 = 1'b1;
        chk16("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("reset_sel", 32'(sel16), 32'd0);

        // Vector table
        for (int i = 0; i < NVEC; i++) begin
            issue16(vecs[i].valid, vecs[i].op, vecs[i].cond, vecs[i].n, vecs[i].jump, vecs[i].rd);
            chk16($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_wen, vecs[i].exp_halt, 1'b0);
            if (vecs[i].exp_wen) begin
                chk($sformatf("vec%0d_sel", i), 32'(sel16), 32'(vecs[i].exp_sel));
            end
        end

        // Reset leaves HALT
        reset16();
        chk16("unhalt", 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("unhalt_sel", 32'(sel16), 32'd0);

        // Nested CALL/RTN returns in LIFO order
        issue16(1'b1, 5'b00001, 2'd0, 16'h0100, 1'b0, 16'h0);
        issue16(1'b1, 5'b00001, 2'd0, 16'h0200, 1'b0, 16'h0);
        issue16(1'b1, 5'b00001, 2'd0, 16'h0300, 1'b0, 16'h0);
        chk16("call3", 16'h0300, 1'b1, 1'b0, 1'b0);
        issue16(1'b1, 5'b11100, 2'd0, 16'h0, 1'b0, 16'h0);
        chk16("rtn1", 16'h0202, 1'b0, 1'b0, 1'b0);
        issue16(1'b1, 5'b11100, 2'd0, 16'h0, 1'b0, 16'h0);
        chk16("rtn2", 16'h0102, 1'b0, 1'b0, 1'b0);
        issue16(1'b1, 5'b11100, 2'd0, 16'h0, 1'b0, 16'h0);
        chk16("rtn3", 16'h0002, 1'b0, 1'b0, 1'b0);

        // Overflow: 8 CALLs fit, the 9th halts with ras_err
        reset16();
        for (int i = 0; i < 8; i++) begin
            issue16(1'b1, 5'b00001, 2'd0, 16'(16'h0100 + i * 16), 1'b0, 16'h0);
            chk16($sformatf("ovf_call%0d", i), 16'(16'h0100 + i * 16), 1'b1, 1'b0, 1'b0);
        end
        issue16(1'b1, 5'b00001, 2'd0, 16'h0900, 1'b0, 16'h0);
        chk16("ovf_call8", 16'h0170, 1'b0, 1'b1, 1'b1);
        issue16(1'b1, 5'b00000, 2'd0, 16'h0, 1'b0, 16'h0);
        chk16("ovf_ignored", 16'h0170, 1'b0, 1'b1, 1'b1);
        reset16();
        chk16("ovf_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Underflow: RTN straight after reset
        issue16(1'b1, 5'b11100, 2'd0, 16'h0, 1'b0, 16'h0);
        chk16("udf_rtn", 16'h0000, 1'b0, 1'b1, 1'b1);

        // Reset coinciding with an accepted instruction discards it
        reset16();
        issue16(1'b1, 5'b00101, 2'd0, 16'h0077, 1'b0, 16'h0);
        chk16("pre_midrst", 16'h0077, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n16           = 1'b0;
        bus16.instr_valid = 1'b1;
        bus16.instr       = {5'b00101, 11'd0};
        bus16.N           = 16'h0123;
        @(posedge clk);
        #1;
        rst_n16 = 1'b1;
        $display("txn16 reset with JMP I pending -> pc=%h", pc16);
        chk16("midrst", 16'h0000, 1'b0, 1'b0, 1'b0);
        issue16(1'b0, 5'b00000, 2'd0, 16'h0, 1'b0, 16'h0);
        chk16("midrst_idle", 16'h0000, 1'b0, 1'b0, 1'b0);

        // DW=8: PC wrap, halt, and reset recovery
        @(negedge clk);
        rst_n8 = 1'b1;
        chk("dw8_reset_pc", 32'(pc8), 32'h00);
        chk("dw8_reset_addr2", 32'(addr2_8), 32'h01);
        issue8(1'b1, 5'b00101, 8'hFF);
        chk("dw8_jmp_pc", 32'(pc8), 32'hFF);
        chk("dw8_jmp_addr2", 32'(addr2_8), 32'h00);
        issue8(1'b1, 5'b00000, 8'h00);
        chk("dw8_wrap_pc", 32'(pc8), 32'h00);
        chk("dw8_wrap_addr1", 32'(addr1_8), 32'h00);
        issue8(1'b1, 5'b11111, 8'h00);
        chk("dw8_stp_pc", 32'(pc8), 32'h00);
        chk("dw8_stp_halted", 32'(halted8), 32'd1);
        chk("dw8_stp_ready", 32'(bus8.instr_ready), 32'd0);
        chk("dw8_stp_err", 32'(ras_err8), 32'd0);
        @(negedge clk);
        rst_n8 = 1'b0;
        @(posedge clk);
        #1;
        rst_n8 = 1'b1;
        $display("txn8 reset -> pc=%h halted=%0b", pc8, halted8);
        chk("dw8_rst_pc", 32'(pc8), 32'h00);
        chk("dw8_rst_halted", 32'(halted8), 32'd0);
        chk("dw8_rst_ready", 32'(bus8.instr_ready), 32'd1);
        chk("dw8_rst_wen", 32'(rd_wen8), 32'd0);
        chk("dw8_rst_sel", 32'(sel8), 32'd0);
        chk("dw8_rst_rs_wen", 32'(rs_wen8), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
